// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V controller: FSM states, datapath mux selects,
// ALU op classes, immediate formats and opcode constants.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9,
    StJal      = 4'd10,
    StJalr     = 4'd11,
    StUpper    = 4'd12
  } state_e;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;
  localparam logic [1:0] SrcAZero  = 2'b11;

  localparam logic [1:0] SrcBRs2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic [1:0] ResAluOut = 2'b00;
  localparam logic [1:0] ResRdData = 2'b01;
  localparam logic [1:0] ResAluRes = 2'b10;

  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;
  localparam logic [1:0] AluUpper = 2'b11;

  localparam logic [2:0] ImmI = 3'b000;
  localparam logic [2:0] ImmS = 3'b001;
  localparam logic [2:0] ImmB = 3'b010;
  localparam logic [2:0] ImmJ = 3'b011;
  localparam logic [2:0] ImmU = 3'b100;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  // Only beq/bne are supported; every other funct3 is never taken.
  function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
    case (funct3)
      3'b000:  return zero;
      3'b001:  return ~zero;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_imm_decode.sv
// Opcode to immediate-format select for the shared immediate extender.
module mc_imm_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] op_i,
  output logic [2:0] imm_src_o
);

  always_comb begin
    imm_src_o = ImmI;
    case (op_i)
      OpStore:         imm_src_o = ImmS;
      OpBranch:        imm_src_o = ImmB;
      OpJal:           imm_src_o = ImmJ;
      OpLui, OpAuipc:  imm_src_o = ImmU;
      default:         imm_src_o = ImmI;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore-style main controller for a multicycle RISC-V core.
// Define MULTICYCLE_CTRL_UPPER_EN to include the UPPER state (lui/auipc support).
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       zero,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       illegal
);

  state_e state_q, state_d;
  logic   pc_update, branch, ir_write, mem_write, reg_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = StFetch;
    pc_update = 1'b0;
    branch    = 1'b0;
    ir_write  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = SrcAPc;
    ALUSrcB   = SrcBRs2;
    ResultSrc = ResAluOut;
    ALUOp     = AluAdd;
    illegal   = 1'b0;
    case (state_q)
      StFetch: begin
        ir_write  = 1'b1;
        ALUSrcB   = SrcBFour;
        ResultSrc = ResAluRes;
        pc_update = 1'b1;
        state_d   = StDecode;
      end
      StDecode: begin
        ALUSrcA = SrcAOldPc;
        ALUSrcB = SrcBImm;
        case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecR;
          OpIType:         state_d = StExecI;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = StJal;
          OpJalr:          state_d = StJalr;
`ifdef MULTICYCLE_CTRL_UPPER_EN
          OpLui, OpAuipc:  state_d = StUpper;
`endif
          default:         illegal = 1'b1;
        endcase
      end
      StMemAdr: begin
        ALUSrcA = SrcARs1;
        ALUSrcB = SrcBImm;
        state_d = op[5] ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        AdrSrc  = 1'b1;
        state_d = StMemWb;
      end
      StMemWb: begin
        ResultSrc = ResRdData;
        reg_write = 1'b1;
      end
      StMemWrite: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
      end
      StExecR: begin
        ALUSrcA = SrcARs1;
        ALUSrcB = SrcBRs2;
        ALUOp   = AluFunct;
        state_d = StAluWb;
      end
      StExecI: begin
        ALUSrcA = SrcARs1;
        ALUSrcB = SrcBImm;
        ALUOp   = AluFunct;
        state_d = StAluWb;
      end
      StAluWb: begin
        reg_write = 1'b1;
      end
      StBranch: begin
        ALUSrcA = SrcARs1;
        ALUSrcB = SrcBRs2;
        ALUOp   = AluSub;
        branch  = 1'b1;
      end
      StJalr: begin
        // Target rs1+imm lands in ALUOut; JAL then loads it into PC while writing PC+4.
        ALUSrcA = SrcARs1;
        ALUSrcB = SrcBImm;
        state_d = StJal;
      end
      StJal: begin
        ALUSrcA   = SrcAOldPc;
        ALUSrcB   = SrcBFour;
        pc_update = 1'b1;
        state_d   = StAluWb;
      end
`ifdef MULTICYCLE_CTRL_UPPER_EN
      StUpper: begin
        ALUSrcA = op[5] ? SrcAZero : SrcAOldPc;
        ALUSrcB = SrcBImm;
        ALUOp   = AluUpper;
        state_d = StAluWb;
      end
`endif
      default: state_d = StFetch;
    endcase
  end

  // Write enables are held low for the whole reset pulse, not just until the state clears.
  assign PCWrite  = ~reset & (pc_update | (branch & branch_taken(funct3, zero)));
  assign IRWrite  = ~reset & ir_write;
  assign MemWrite = ~reset & mem_write;
  assign RegWrite = ~reset & reg_write;

  mc_imm_decode u_imm_decode (
    .op_i      (op),
    .imm_src_o (ImmSrc)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; state sequence inferred from output vectors.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero;
  logic       PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, illegal;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUOp;
  logic [2:0] ImmSrc;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .funct3    (funct3),
    .zero      (zero),
    .PCWrite   (PCWrite),
    .IRWrite   (IRWrite),
    .MemWrite  (MemWrite),
    .RegWrite  (RegWrite),
    .AdrSrc    (AdrSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .ALUOp     (ALUOp),
    .ImmSrc    (ImmSrc),
    .illegal   (illegal)
  );

  // {PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, illegal}
  logic [13:0] ctl;
  assign ctl = {PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                ALUOp, illegal};

  function automatic logic [13:0] ev(input logic pcw, input logic irw, input logic mw,
                                     input logic rw, input logic adr, input logic [1:0] a,
                                     input logic [1:0] b, input logic [1:0] r,
                                     input logic [1:0] aop, input logic ill);
    return {pcw, irw, mw, rw, adr, a, b, r, aop, ill};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_step(input string tag, input logic [13:0] exp);
    check_eq(tag, {18'd0, ctl}, {18'd0, exp});
    step();
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic z);
    op     = o;
    funct3 = f3;
    zero   = z;
    #1;
  endtask

  logic [13:0] v_fetch, v_rst, v_dec, v_dec_ill, v_memadr, v_memrd, v_memwb, v_memwr;
  logic [13:0] v_execr, v_execi, v_aluwb, v_br_t, v_br_n, v_jalr, v_jal;

  initial begin
    v_fetch   = ev(1, 1, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 0);
    v_rst     = ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 0);
    v_dec     = ev(0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0);
    v_dec_ill = ev(0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 1);
    v_memadr  = ev(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0);
    v_memrd   = ev(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    v_memwb   = ev(0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b01, 2'b00, 0);
    v_memwr   = ev(0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    v_execr   = ev(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b10, 0);
    v_execi   = ev(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b10, 0);
    v_aluwb   = ev(0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    v_br_t    = ev(1, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b01, 0);
    v_br_n    = ev(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b01, 0);
    v_jalr    = ev(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0);
    v_jal     = ev(1, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 2'b00, 0);

    reset  = 1'b1;
    op     = 7'd0;
    funct3 = 3'd0;
    zero   = 1'b0;
    #2;
    check_eq("reset_vec", {18'd0, ctl}, {18'd0, v_rst});
    step();
    check_eq("reset_hold", {18'd0, ctl}, {18'd0, v_rst});
    reset = 1'b0;

    // lw
    set_instr(7'b0000011, 3'b010, 1'b0);
    check_eq("imm_lw", {29'd0, ImmSrc}, 32'd0);
    chk_step("lw_fetch", v_fetch);
    chk_step("lw_decode", v_dec);
    chk_step("lw_memadr", v_memadr);
    chk_step("lw_memread", v_memrd);
    chk_step("lw_memwb", v_memwb);

    // sw
    set_instr(7'b0100011, 3'b010, 1'b0);
    check_eq("imm_sw", {29'd0, ImmSrc}, 32'd1);
    chk_step("sw_fetch", v_fetch);
    chk_step("sw_decode", v_dec);
    chk_step("sw_memadr", v_memadr);
    chk_step("sw_memwrite", v_memwr);

    // R-type and I-type
    set_instr(7'b0110011, 3'b000, 1'b0);
    chk_step("r_fetch", v_fetch);
    chk_step("r_decode", v_dec);
    chk_step("r_exec", v_execr);
    chk_step("r_aluwb", v_aluwb);
    set_instr(7'b0010011, 3'b000, 1'b0);
    chk_step("i_fetch", v_fetch);
    chk_step("i_decode", v_dec);
    chk_step("i_exec", v_execi);
    chk_step("i_aluwb", v_aluwb);

    // branches: beq taken/not, bne taken/not, unsupported funct3 never taken
    set_instr(7'b1100011, 3'b000, 1'b1);
    check_eq("imm_b", {29'd0, ImmSrc}, 32'd2);
    chk_step("beq1_fetch", v_fetch);
    chk_step("beq1_decode", v_dec);
    chk_step("beq1_branch", v_br_t);
    set_instr(7'b1100011, 3'b000, 1'b0);
    chk_step("beq0_fetch", v_fetch);
    chk_step("beq0_decode", v_dec);
    chk_step("beq0_branch", v_br_n);
    set_instr(7'b1100011, 3'b001, 1'b0);
    chk_step("bne0_fetch", v_fetch);
    chk_step("bne0_decode", v_dec);
    chk_step("bne0_branch", v_br_t);
    set_instr(7'b1100011, 3'b001, 1'b1);
    chk_step("bne1_fetch", v_fetch);
    chk_step("bne1_decode", v_dec);
    chk_step("bne1_branch", v_br_n);
    set_instr(7'b1100011, 3'b100, 1'b1);
    chk_step("blt_fetch", v_fetch);
    chk_step("blt_decode", v_dec);
    chk_step("blt_branch", v_br_n);

    // jal, jalr
    set_instr(7'b1101111, 3'b000, 1'b0);
    check_eq("imm_j", {29'd0, ImmSrc}, 32'd3);
    chk_step("jal_fetch", v_fetch);
    chk_step("jal_decode", v_dec);
    chk_step("jal_jal", v_jal);
    chk_step("jal_aluwb", v_aluwb);
    set_instr(7'b1100111, 3'b000, 1'b0);
    check_eq("imm_jalr", {29'd0, ImmSrc}, 32'd0);
    chk_step("jalr_fetch", v_fetch);
    chk_step("jalr_decode", v_dec);
    chk_step("jalr_jalr", v_jalr);
    chk_step("jalr_jal", v_jal);
    chk_step("jalr_aluwb", v_aluwb);

    // illegal opcode
    set_instr(7'b0000000, 3'b000, 1'b0);
    chk_step("ill_fetch", v_fetch);
    chk_step("ill_decode", v_dec_ill);
    chk_step("ill_back_fetch", v_fetch);
    chk_step("ill_decode2", v_dec_ill);

    // lui / auipc
    set_instr(7'b0110111, 3'b000, 1'b0);
    check_eq("imm_u", {29'd0, ImmSrc}, 32'd4);
    chk_step("lui_fetch", v_fetch);
`ifdef MULTICYCLE_CTRL_UPPER_EN
    chk_step("lui_decode", v_dec);
    chk_step("lui_upper", ev(0, 0, 0, 0, 0, 2'b11, 2'b01, 2'b00, 2'b11, 0));
    chk_step("lui_aluwb", v_aluwb);
    set_instr(7'b0010111, 3'b000, 1'b0);
    chk_step("auipc_fetch", v_fetch);
    chk_step("auipc_decode", v_dec);
    chk_step("auipc_upper", ev(0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b11, 0));
    chk_step("auipc_aluwb", v_aluwb);
`else
    chk_step("lui_decode_ill", v_dec_ill);
    set_instr(7'b0010111, 3'b000, 1'b0);
    chk_step("auipc_fetch", v_fetch);
    chk_step("auipc_decode_ill", v_dec_ill);
`endif

    // reset pulse in the middle of a load (during MEMREAD)
    set_instr(7'b0000011, 3'b010, 1'b0);
    chk_step("rlw_fetch", v_fetch);
    chk_step("rlw_decode", v_dec);
    chk_step("rlw_memadr", v_memadr);
    check_eq("rlw_memread", {18'd0, ctl}, {18'd0, v_memrd});
    reset = 1'b1;
    #1;
    check_eq("rlw_async_fetch", {18'd0, ctl}, {18'd0, v_rst});
    reset = 1'b0;
    #1;
    check_eq("rlw_irwrite", {31'd0, IRWrite}, 32'd1);
    step();
    check_eq("rlw_then_decode", {18'd0, ctl}, {18'd0, v_dec});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
